// File: rtl/idu_pkg.sv
// Shared decode-stage types: opcodes, ALU operation codes, jump kinds, FSM states
// and the packed decoded-instruction bundle.
package idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  // M-extension codes stay reserved when the multiply/divide decode is not built.
  typedef enum logic [4:0] {
    ALU_NOP    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_SLL    = 5'd3,
    ALU_SLT    = 5'd4,
    ALU_SLTU   = 5'd5,
    ALU_XOR    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_OR     = 5'd9,
    ALU_AND    = 5'd10,
    ALU_LUI    = 5'd11,
    ALU_AUIPC  = 5'd12,
    ALU_JAL    = 5'd13,
    ALU_JALR   = 5'd14,
    ALU_BEQ    = 5'd15,
    ALU_BNE    = 5'd16,
    ALU_BLT    = 5'd17,
    ALU_BGE    = 5'd18,
    ALU_BLTU   = 5'd19,
    ALU_BGEU   = 5'd20,
    ALU_ECALL  = 5'd21,
    ALU_EBREAK = 5'd22,
    ALU_MUL    = 5'd23,
    ALU_MULH   = 5'd24,
    ALU_MULHSU = 5'd25,
    ALU_MULHU  = 5'd26,
    ALU_DIV    = 5'd27,
    ALU_DIVU   = 5'd28,
    ALU_REM    = 5'd29,
    ALU_REMU   = 5'd30
  } alu_op_e;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'd0,
    JMP_BRANCH = 2'd1,
    JMP_JAL    = 2'd2,
    JMP_JALR   = 2'd3
  } jmp_type_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  rd_id;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_wr_en;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [2:0]  mem_size;
    jmp_type_e   jmp_type;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Shared by OP and OP-IMM; alt selects SUB/SRA (funct7[5]).
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32I decoder: instruction word -> decoded bundle, no state.
// Multiply/divide decode is built only when IDU_RVM_EN is defined.
module idu_dec
  import idu_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;
  logic        ill;
  dec_t        d;

  assign opc    = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign imm_i  = sext12(inst_i[31:20]);
  assign imm_s  = sext12({inst_i[31:25], inst_i[11:7]});
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'b0};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_sh = {27'b0, inst_i[24:20]};

  always_comb begin
    d        = '0;
    d.rs1_id = inst_i[19:15];
    d.rs2_id = inst_i[24:20];
    d.rd_id  = inst_i[11:7];
    ill      = 1'b0;

    case (opc)
      OPC_LUI: begin
        d.rd_wr_en = 1'b1;
        d.imm      = imm_u;
        d.alu_op   = ALU_LUI;
      end
      OPC_AUIPC: begin
        d.rd_wr_en = 1'b1;
        d.imm      = imm_u;
        d.alu_op   = ALU_AUIPC;
      end
      OPC_JAL: begin
        d.rd_wr_en = 1'b1;
        d.imm      = imm_j;
        d.alu_op   = ALU_JAL;
        d.jmp_type = JMP_JAL;
      end
      OPC_JALR: begin
        ill        = (f3 != 3'd0);
        d.rs1_en   = 1'b1;
        d.rd_wr_en = 1'b1;
        d.imm      = imm_i;
        d.alu_op   = ALU_JALR;
        d.jmp_type = JMP_JALR;
      end
      OPC_BRANCH: begin
        d.rs1_en   = 1'b1;
        d.rs2_en   = 1'b1;
        d.imm      = imm_b;
        d.jmp_type = JMP_BRANCH;
        case (f3)
          3'd0:    d.alu_op = ALU_BEQ;
          3'd1:    d.alu_op = ALU_BNE;
          3'd4:    d.alu_op = ALU_BLT;
          3'd5:    d.alu_op = ALU_BGE;
          3'd6:    d.alu_op = ALU_BLTU;
          3'd7:    d.alu_op = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ill         = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        d.rs1_en    = 1'b1;
        d.rd_wr_en  = 1'b1;
        d.mem_rd_en = 1'b1;
        d.mem_size  = f3;
        d.imm       = imm_i;
        d.alu_op    = ALU_ADD;
      end
      OPC_STORE: begin
        ill         = (f3 > 3'd2);
        d.rs1_en    = 1'b1;
        d.rs2_en    = 1'b1;
        d.mem_wr_en = 1'b1;
        d.mem_size  = f3;
        d.imm       = imm_s;
        d.alu_op    = ALU_ADD;
      end
      OPC_OPIMM: begin
        d.rs1_en   = 1'b1;
        d.rd_wr_en = 1'b1;
        d.alu_op   = alu_from_f3(f3, (f3 == 3'd5) && f7[5]);
        // Shifts carry only the shamt; funct7 must be a valid shift encoding.
        if (f3 == 3'd1) begin
          ill   = (f7 != F7_BASE);
          d.imm = imm_sh;
        end else if (f3 == 3'd5) begin
          ill   = (f7 != F7_BASE) && (f7 != F7_ALT);
          d.imm = imm_sh;
        end else begin
          d.imm = imm_i;
        end
      end
      OPC_OP: begin
        d.rs1_en   = 1'b1;
        d.rs2_en   = 1'b1;
        d.rd_wr_en = 1'b1;
        if (f7 == F7_BASE) begin
          d.alu_op = alu_from_f3(f3, 1'b0);
        end else if (f7 == F7_ALT) begin
          ill      = (f3 != 3'd0) && (f3 != 3'd5);
          d.alu_op = alu_from_f3(f3, 1'b1);
        end else if (f7 == F7_MULDIV) begin
`ifdef IDU_RVM_EN
          case (f3)
            3'd0:    d.alu_op = ALU_MUL;
            3'd1:    d.alu_op = ALU_MULH;
            3'd2:    d.alu_op = ALU_MULHSU;
            3'd3:    d.alu_op = ALU_MULHU;
            3'd4:    d.alu_op = ALU_DIV;
            3'd5:    d.alu_op = ALU_DIVU;
            3'd6:    d.alu_op = ALU_REM;
            default: d.alu_op = ALU_REMU;
          endcase
`else
          ill = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_FENCE: begin
        ill = (f3 != 3'd0);
      end
      OPC_SYSTEM: begin
        if (inst_i[31:7] == 25'h0000000) begin
          d.alu_op = ALU_ECALL;
        end else if (inst_i[31:7] == 25'h0002000) begin
          d.alu_op = ALU_EBREAK;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase

    if ((inst_i[1:0] != 2'b11) || (inst_i == 32'h0)) begin
      ill = 1'b1;
    end

    if (d.rd_id == 5'd0) begin
      d.rd_wr_en = 1'b0;
    end

    // Illegal words still flow downstream, but inert.
    if (ill) begin
      d.rs1_en    = 1'b0;
      d.rs2_en    = 1'b0;
      d.rd_wr_en  = 1'b0;
      d.mem_rd_en = 1'b0;
      d.mem_wr_en = 1'b0;
      d.mem_size  = 3'd0;
      d.imm       = 32'h0;
      d.alu_op    = ALU_NOP;
      d.jmp_type  = JMP_NONE;
    end
    d.illegal = ill;
  end

  assign dec_o = d;

endmodule

// File: rtl/idu.sv
// Single-entry decode stage: captures one fetched instruction, holds the decoded bundle
// until execute takes it or a flush drops it; outputs valid one cycle after capture.
module idu
  import idu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_ifu_valid,
  output logic                  o_idu_ready,
  input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
  input  logic [ADDR_WIDTH-1:0] i_ifu_pc_next,
  input  logic [INST_WIDTH-1:0] i_ifu_inst,
  input  logic                  i_idu_flush,
  output logic                  o_idu_valid,
  input  logic                  i_exu_ready,
  output logic [ADDR_WIDTH-1:0] o_idu_pc,
  output logic [ADDR_WIDTH-1:0] o_idu_pc_next,
  output logic [31:0]           o_idu_inst,
  output logic [4:0]            o_idu_rs1_id,
  output logic [4:0]            o_idu_rs2_id,
  output logic [4:0]            o_idu_rd_id,
  output logic                  o_idu_rs1_en,
  output logic                  o_idu_rs2_en,
  output logic                  o_idu_rd_wr_en,
  output logic [31:0]           o_idu_imm,
  output logic [4:0]            o_idu_alu_op,
  output logic                  o_idu_mem_rd_en,
  output logic                  o_idu_mem_wr_en,
  output logic [2:0]            o_idu_mem_size,
  output logic [1:0]            o_idu_jmp_type,
  output logic                  o_idu_illegal
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_next_q, pc_next_d;
  logic [31:0]           inst_q, inst_d;
  dec_t                  dec_q, dec_d;
  dec_t                  dec_w;
  logic                  capture;

  idu_dec u_dec (
    .inst_i (i_ifu_inst[31:0]),
    .dec_o  (dec_w)
  );

  // Capture only from S_IDLE, so a release cycle never accepts a new instruction.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_ifu_valid) begin
          state_d = S_WAIT;
          capture = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_idu_flush || i_exu_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    inst_d    = inst_q;
    dec_d     = dec_q;
    if (capture) begin
      pc_d      = i_ifu_pc;
      pc_next_d = i_ifu_pc_next;
      inst_d    = i_ifu_inst[31:0];
      dec_d     = dec_w;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      pc_next_q <= '0;
      inst_q    <= '0;
      dec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      inst_q    <= inst_d;
      dec_q     <= dec_d;
    end
  end

  assign o_idu_ready     = (state_q == S_IDLE);
  assign o_idu_valid     = (state_q == S_WAIT);
  assign o_idu_pc        = pc_q;
  assign o_idu_pc_next   = pc_next_q;
  assign o_idu_inst      = inst_q;
  assign o_idu_rs1_id    = dec_q.rs1_id;
  assign o_idu_rs2_id    = dec_q.rs2_id;
  assign o_idu_rd_id     = dec_q.rd_id;
  assign o_idu_rs1_en    = dec_q.rs1_en;
  assign o_idu_rs2_en    = dec_q.rs2_en;
  assign o_idu_rd_wr_en  = dec_q.rd_wr_en;
  assign o_idu_imm       = dec_q.imm;
  assign o_idu_alu_op    = dec_q.alu_op;
  assign o_idu_mem_rd_en = dec_q.mem_rd_en;
  assign o_idu_mem_wr_en = dec_q.mem_wr_en;
  assign o_idu_mem_size  = dec_q.mem_size;
  assign o_idu_jmp_type  = dec_q.jmp_type;
  assign o_idu_illegal   = dec_q.illegal;

endmodule
